// File: rtl/riscv_pkg.sv
// Constants shared by the RISC-V front end: bus widths, reset vector, fetch
// FSM encodings and the base opcodes the downstream parser decodes.
package riscv_pkg;

    localparam int          INSTR_WIDTH = 32;
    localparam int          ADDR_WIDTH  = 32;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          FIFO_DEPTH  = 2;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_DROP  = 1'b1;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, instr} entries between the fetch FSM and the
// parser; flush empties it in one cycle and beats any same-cycle push or pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    import riscv_pkg::*;

    localparam int                PW          = $clog2(DEPTH);
    localparam logic [PW:0]       LP_CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]       LP_CNT_FULL = (PW + 1)'(DEPTH);
    localparam logic [PW-1:0]     LP_PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == LP_CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + LP_PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + LP_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request at a time, buffered
// responses to the parser, and redirect handling that drops stale responses.
module instr_fetch #(
    parameter int                    INSTR_WIDTH = riscv_pkg::INSTR_WIDTH,
    parameter int                    ADDR_WIDTH  = riscv_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = riscv_pkg::RESET_PC,
    parameter int                    FIFO_DEPTH  = riscv_pkg::FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   instr_ready
);
    import riscv_pkg::*;

    localparam int                    CW            = $clog2(FIFO_DEPTH) + 1;
    localparam int                    EW            = ADDR_WIDTH + INSTR_WIDTH;
    localparam logic [CW-1:0]         LP_CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]         LP_CNT_DEPTH  = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_PC_STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] LP_ALIGN_MASK = ADDR_WIDTH'(3);

    logic [0:0]            r_state;
    logic                  r_req;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;

    logic [0:0]            w_state_n;
    logic                  w_req_n;
    logic [ADDR_WIDTH-1:0] w_addr_n;
    logic [ADDR_WIDTH-1:0] w_pc_n;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_done;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [EW-1:0]         w_head;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_cnt_n;
    logic                  w_room;

    assign w_target = redirect_pc & ~LP_ALIGN_MASK;
    assign w_done   = r_req && imem_ack;
    assign w_pop    = instr_valid && instr_ready;
    assign w_push   = w_done && (r_state == ST_FETCH) && !redirect_valid && (!w_full || w_pop);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_addr, imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Occupancy after this edge decides whether a new request may start next cycle.
    always_comb begin
        w_cnt_n = w_count;
        if (redirect_valid) begin
            w_cnt_n = '0;
        end else begin
            if (w_push) w_cnt_n = w_cnt_n + LP_CNT_ONE;
            if (w_pop)  w_cnt_n = w_cnt_n - LP_CNT_ONE;
        end
        w_room = (w_cnt_n < LP_CNT_DEPTH);
    end

    always_comb begin
        w_state_n = r_state;
        w_req_n   = r_req;
        w_addr_n  = r_addr;
        w_pc_n    = r_fetch_pc;
        if (redirect_valid) begin
            w_pc_n = w_target;
            if (r_req && !imem_ack) begin
                w_state_n = ST_DROP;
            end else begin
                w_state_n = ST_FETCH;
                w_req_n   = 1'b1;
                w_addr_n  = w_target;
            end
        end else if (r_state == ST_DROP) begin
            if (w_done) begin
                w_state_n = ST_FETCH;
                w_req_n   = w_room;
                w_addr_n  = r_fetch_pc;
            end
        end else if (w_done || !r_req) begin
            if (w_done) w_pc_n = r_fetch_pc + LP_PC_STEP;
            w_req_n = w_room;
            if (w_room) w_addr_n = w_pc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_n;
            r_req      <= w_req_n;
            r_addr     <= w_addr_n;
            r_fetch_pc <= w_pc_n;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = !w_empty;
    assign instr       = w_empty ? '0 : w_head[INSTR_WIDTH-1:0];
    assign instr_pc    = w_empty ? '0 : w_head[EW-1:INSTR_WIDTH];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: per-cycle vector table with a scoreboard of expected
// {pc, instr} entries, plus a hand-written fetch latency sequence.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;

    logic        a_req, b_req, a_valid, b_valid;
    logic [31:0] a_addr, b_addr, a_rdata, b_rdata;
    logic [31:0] a_instr, b_instr, a_pc, b_pc;

    logic        sel;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;

    int checks   = 0;
    int failures = 0;
    int step     = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0F0F;
    endfunction

    assign a_rdata = mem_word(a_addr);
    assign b_rdata = mem_word(b_addr);

    assign s_req   = sel ? b_req   : a_req;
    assign s_addr  = sel ? b_addr  : a_addr;
    assign s_valid = sel ? b_valid : a_valid;
    assign s_instr = sel ? b_instr : a_instr;
    assign s_pc    = sel ? b_pc    : a_pc;

    instr_fetch #(
        .INSTR_WIDTH (32),
        .ADDR_WIDTH  (32),
        .RESET_PC    (32'h0000_0000),
        .FIFO_DEPTH  (2)
    ) u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (a_req),
        .imem_addr      (a_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (a_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (a_valid),
        .instr          (a_instr),
        .instr_pc       (a_pc),
        .instr_ready    (instr_ready)
    );

    instr_fetch #(
        .INSTR_WIDTH (32),
        .ADDR_WIDTH  (32),
        .RESET_PC    (32'hFFFF_FFFC),
        .FIFO_DEPTH  (2)
    ) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (b_req),
        .imem_addr      (b_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (b_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (b_valid),
        .instr          (b_instr),
        .instr_pc       (b_pc),
        .instr_ready    (instr_ready)
    );

    typedef struct {
        bit          pre;
        bit          sel;
        bit          rst;
        bit          ack;
        bit          ready;
        bit          redir;
        logic [31:0] rpc;
        bit          keep;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t v(bit pre, bit s, bit r, bit ack, bit rdy, bit redir,
                               logic [31:0] rpc, bit keep, bit req,
                               logic [31:0] addr, bit valid);
        vec_t t;
        t.pre = pre; t.sel = s; t.rst = r; t.ack = ack; t.ready = rdy;
        t.redir = redir; t.rpc = rpc; t.keep = keep; t.exp_req = req;
        t.exp_addr = addr; t.exp_valid = valid;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (step %0d): got 0x%08h, want 0x%08h", name, step, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(posedge clk);
        @(posedge clk);
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        bit prev_rst;
        int n;
        rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; sel = 1'b0;

        // Back-to-back streaming with ack and ready tied high
        tbl.push_back(v(1,0,0,1,1,0,0,0, 0,32'h0,0));
        tbl.push_back(v(0,0,0,1,1,0,0,1, 1,32'h0,0));
        tbl.push_back(v(0,0,0,1,1,0,0,1, 1,32'h4,1));
        tbl.push_back(v(0,0,0,1,1,0,0,1, 1,32'h8,1));
        tbl.push_back(v(0,0,0,0,1,0,0,0, 1,32'hC,1));
        tbl.push_back(v(0,0,0,0,1,0,0,0, 1,32'hC,0));
        // Back-pressure: two requests fill the buffer, then refetch resumes at 0x8
        tbl.push_back(v(1,0,0,1,0,0,0,0, 0,32'h0,0));
        tbl.push_back(v(0,0,0,1,0,0,0,1, 1,32'h0,0));
        tbl.push_back(v(0,0,0,1,0,0,0,1, 1,32'h4,1));
        tbl.push_back(v(0,0,0,1,0,0,0,0, 0,32'h0,1));
        tbl.push_back(v(0,0,0,1,0,0,0,0, 0,32'h0,1));
        tbl.push_back(v(0,0,0,0,1,0,0,0, 0,32'h0,1));
        tbl.push_back(v(0,0,0,1,1,0,0,1, 1,32'h8,1));
        tbl.push_back(v(0,0,0,0,1,0,0,0, 1,32'hC,1));
        tbl.push_back(v(0,0,0,0,1,0,0,0, 1,32'hC,0));
        // Redirect during a slow request: late response dropped
        tbl.push_back(v(1,0,0,0,1,0,0,0,            0,32'h0,0));
        tbl.push_back(v(0,0,0,0,1,1,32'h100,0,      1,32'h0,0));
        tbl.push_back(v(0,0,0,0,1,0,0,0,            1,32'h0,0));
        tbl.push_back(v(0,0,0,1,1,0,0,0,            1,32'h0,0));
        tbl.push_back(v(0,0,0,0,1,0,0,0,            1,32'h100,0));
        tbl.push_back(v(0,0,0,1,1,0,0,1,            1,32'h100,0));
        tbl.push_back(v(0,0,0,0,1,0,0,0,            1,32'h104,1));
        // Redirect coinciding with ack, unaligned target
        tbl.push_back(v(1,0,0,0,1,1,32'h10,0,       0,32'h0,0));
        tbl.push_back(v(0,0,0,1,1,1,32'h203,0,      1,32'h10,0));
        tbl.push_back(v(0,0,0,0,1,0,0,0,            1,32'h200,0));
        tbl.push_back(v(0,0,0,1,1,0,0,1,            1,32'h200,0));
        tbl.push_back(v(0,0,0,0,1,0,0,0,            1,32'h204,1));
        // Redirect while dropping, then redirect with a pop
        tbl.push_back(v(1,0,0,0,1,0,0,0,            0,32'h0,0));
        tbl.push_back(v(0,0,0,0,1,1,32'h40,0,       1,32'h0,0));
        tbl.push_back(v(0,0,0,0,1,1,32'h80,0,       1,32'h0,0));
        tbl.push_back(v(0,0,0,1,1,0,0,0,            1,32'h0,0));
        tbl.push_back(v(0,0,0,1,0,0,0,1,            1,32'h80,0));
        tbl.push_back(v(0,0,0,0,1,1,32'h300,0,      1,32'h84,1));
        tbl.push_back(v(0,0,0,1,1,0,0,0,            1,32'h84,0));
        tbl.push_back(v(0,0,0,1,1,0,0,1,            1,32'h300,0));
        tbl.push_back(v(0,0,0,0,1,0,0,0,            1,32'h304,1));
        // Address wrap from 0xFFFFFFFC, then reset in the middle of a wait
        tbl.push_back(v(1,1,0,1,1,0,0,0,            0,32'hFFFF_FFFC,0));
        tbl.push_back(v(0,1,0,1,1,0,0,1,            1,32'hFFFF_FFFC,0));
        tbl.push_back(v(0,1,0,1,1,0,0,1,            1,32'h0,1));
        tbl.push_back(v(0,1,0,0,0,0,0,0,            1,32'h4,1));
        tbl.push_back(v(0,1,1,0,0,0,0,0,            1,32'h4,1));
        tbl.push_back(v(0,1,0,1,1,0,0,0,            0,32'hFFFF_FFFC,0));
        tbl.push_back(v(0,1,0,0,1,0,0,0,            1,32'hFFFF_FFFC,0));

        prev_rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t t;
            t = tbl[i];
            step = i;
            if (t.pre) do_reset();
            @(negedge clk);
            sel = t.sel; rst = t.rst; imem_ack = t.ack; instr_ready = t.ready;
            redirect_valid = t.redir; redirect_pc = t.rpc;
            #1;
            chk("imem_req", 32'(s_req), 32'(t.exp_req));
            if (t.exp_req || t.pre || prev_rst) chk("imem_addr", s_addr, t.exp_addr);
            chk("instr_valid", 32'(s_valid), 32'(t.exp_valid));
            if (t.exp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard (step %0d): got valid output, want an expected entry", i);
                end else begin
                    chk("instr_pc", s_pc, sb[0].pc);
                    chk("instr", s_instr, sb[0].ins);
                    if (t.ready) void'(sb.pop_front());
                end
            end else begin
                chk("instr_pc_empty", s_pc, 32'h0);
                chk("instr_empty", s_instr, 32'h0);
            end
            if (t.redir || t.rst) sb.delete();
            if (t.keep) sb.push_back('{t.exp_addr, mem_word(t.exp_addr)});
            prev_rst = t.rst;
        end

        // Latency: slow ack, instruction visible the cycle after the ack
        step = 1000;
        sel = 1'b0;
        do_reset();
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0; instr_ready = 1'b1;
        n = 0;
        while (!a_req && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("lat_req_seen", 32'(a_req), 32'h1);
        @(negedge clk);
        #1;
        chk("lat_addr_hold", a_addr, 32'h0);
        chk("lat_req_hold", 32'(a_req), 32'h1);
        @(negedge clk);
        imem_ack = 1'b1;
        #1;
        chk("lat_valid_at_ack", 32'(a_valid), 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        chk("lat_valid_after_ack", 32'(a_valid), 32'h1);
        chk("lat_pc", a_pc, 32'h0);
        chk("lat_instr", a_instr, mem_word(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
